// File: rtl/key_event_dec_pkg.sv
// Shared definitions for the key event decoder: FSM states, 50 MHz default
// timing constants and pulse names reused by the washing-machine control FSM.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_REL = 3'd4
  } key_state_e;

  // 50 MHz board: 30 ms long press, 5 ms repeat, 8 ms double-press gap
  localparam logic [23:0] DEF_LONG_CNT   = 24'd1_500_000;
  localparam logic [23:0] DEF_REPEAT_CNT = 24'd250_000;
  localparam logic [23:0] DEF_GAP_CNT    = 24'd400_000;

  typedef enum logic [1:0] {
    PULSE_SHORT  = 2'd0,
    PULSE_LONG   = 2'd1,
    PULSE_REPEAT = 2'd2,
    PULSE_DOUBLE = 2'd3
  } pulse_e;

endpackage

// File: rtl/key_event_dec_if.sv
// Debounced key level in, classified one-cycle event pulses out.
interface key_event_dec_if;
  logic key_press;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic double_pulse;

  modport master (
    output key_press,
    input  short_pulse, long_pulse, repeat_pulse, double_pulse
  );

  modport slave (
    input  key_press,
    output short_pulse, long_pulse, repeat_pulse, double_pulse
  );
endinterface

// File: rtl/key_event_dec.sv
// Classifies each press of an active-low debounced key as short, long (with
// auto-repeat while held) or double, emitting registered one-cycle pulses.
module key_event_dec
  import key_pkg::*;
#(
  parameter logic [23:0] LONG_CNT   = DEF_LONG_CNT,
  parameter logic [23:0] REPEAT_CNT = DEF_REPEAT_CNT,
  parameter logic [23:0] GAP_CNT    = DEF_GAP_CNT,
  parameter bit          DOUBLE_EN  = 1'b1,
  parameter int unsigned CNT_W      = 24
) (
  input  logic            CLK,
  input  logic            RST_N,
  key_event_dec_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 24'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 24'd1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CNT - 24'd1);

  key_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       pulse_q, pulse_nx;
  logic             released;

  assign released = bus.key_press;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pulse_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pulse_q <= pulse_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    pulse_nx = '0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (!released) state_nx = ST_PRESS;
      end
      ST_PRESS: begin
        if (!released) begin
          if (cnt == LONG_LAST) begin
            pulse_nx[PULSE_LONG] = 1'b1;
            state_nx             = ST_HOLD;
            cnt_nx               = '0;
          end
        end else begin
          cnt_nx = '0;
          if (DOUBLE_EN) begin
            state_nx = ST_GAP;
          end else begin
            pulse_nx[PULSE_SHORT] = 1'b1;
            state_nx              = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!released) begin
          if (cnt == REPEAT_LAST) begin
            pulse_nx[PULSE_REPEAT] = 1'b1;
            cnt_nx                 = '0;
          end
        end else begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      ST_GAP: begin
        // A new press wins over gap expiry on the same edge
        if (!released) begin
          pulse_nx[PULSE_DOUBLE] = 1'b1;
          state_nx               = ST_WAIT_REL;
          cnt_nx                 = '0;
        end else if (cnt == GAP_LAST) begin
          pulse_nx[PULSE_SHORT] = 1'b1;
          state_nx              = ST_IDLE;
          cnt_nx                = '0;
        end
      end
      ST_WAIT_REL: begin
        cnt_nx = '0;
        if (released) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.short_pulse  = pulse_q[PULSE_SHORT];
  assign bus.long_pulse   = pulse_q[PULSE_LONG];
  assign bus.repeat_pulse = pulse_q[PULSE_REPEAT];
  assign bus.double_pulse = pulse_q[PULSE_DOUBLE];

endmodule

// File: tb/tb_key_event_dec.sv
// Drives one key waveform into two decoders (double-press on and off) and
// compares every pulse output against a timestamp-based gesture model.
module tb_key_event_dec;

  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int GAP  = 10;

  typedef enum int {M_IDLE, M_DOWN, M_GAP, M_SECOND} mphase_e;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  logic key   = 1'b1;
  int   n      = 0;
  int   checks = 0;
  int   fails  = 0;

  mphase_e ph [2];
  int      t0 [2];
  int      t1 [2];

  always #5 CLK = ~CLK;

  key_event_dec_if bus_d ();
  key_event_dec_if bus_s ();
  assign bus_d.key_press = key;
  assign bus_s.key_press = key;

  key_event_dec #(
    .LONG_CNT(24'd20), .REPEAT_CNT(24'd8), .GAP_CNT(24'd10),
    .DOUBLE_EN(1'b1), .CNT_W(8)
  ) dut_d (.CLK(CLK), .RST_N(RST_N), .bus(bus_d));

  key_event_dec #(
    .LONG_CNT(24'd20), .REPEAT_CNT(24'd8), .GAP_CNT(24'd10),
    .DOUBLE_EN(1'b0), .CNT_W(8)
  ) dut_s (.CLK(CLK), .RST_N(RST_N), .bus(bus_s));

  // Expected pulses as {short, long, repeat, double} after edge n
  task automatic model_step(input int i, input logic k, input bit den,
                            output logic [3:0] p);
    int age;
    p = '0;
    case (ph[i])
      M_IDLE: if (!k) begin ph[i] = M_DOWN; t0[i] = n; end
      M_DOWN: begin
        age = n - t0[i];
        if (!k) begin
          if (age == LONG) p[2] = 1'b1;
          else if (age > LONG && (age - LONG) % REP == 0) p[1] = 1'b1;
        end else if (age > LONG) begin
          ph[i] = M_IDLE;
        end else if (!den) begin
          p[3] = 1'b1; ph[i] = M_IDLE;
        end else begin
          ph[i] = M_GAP; t1[i] = n;
        end
      end
      M_GAP: begin
        if (!k) begin p[0] = 1'b1; ph[i] = M_SECOND; end
        else if (n - t1[i] == GAP) begin p[3] = 1'b1; ph[i] = M_IDLE; end
      end
      M_SECOND: if (k) ph[i] = M_IDLE;
      default: ph[i] = M_IDLE;
    endcase
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, obs, exp);
    end
  endtask

  task automatic check_all(input string pfx, input logic [3:0] ed, input logic [3:0] es);
    check_bit({pfx, "dbl_en.short"},  bus_d.short_pulse,  ed[3]);
    check_bit({pfx, "dbl_en.long"},   bus_d.long_pulse,   ed[2]);
    check_bit({pfx, "dbl_en.repeat"}, bus_d.repeat_pulse, ed[1]);
    check_bit({pfx, "dbl_en.double"}, bus_d.double_pulse, ed[0]);
    check_bit({pfx, "no_dbl.short"},  bus_s.short_pulse,  es[3]);
    check_bit({pfx, "no_dbl.long"},   bus_s.long_pulse,   es[2]);
    check_bit({pfx, "no_dbl.repeat"}, bus_s.repeat_pulse, es[1]);
    check_bit({pfx, "no_dbl.double"}, bus_s.double_pulse, es[0]);
  endtask

  task automatic cycle(input logic k);
    logic [3:0] ed, es;
    key = k;
    @(posedge CLK);
    n++;
    model_step(0, k, 1'b1, ed);
    model_step(1, k, 1'b0, es);
    #1;
    check_all("", ed, es);
  endtask

  task automatic run(input logic k, input int len);
    for (int j = 0; j < len; j++) cycle(k);
  endtask

  task automatic reset_for(input int cyc, input logic k);
    key   = k;
    RST_N = 1'b0;
    #1;
    check_all("rst_assert.", 4'b0, 4'b0);
    repeat (cyc) begin @(posedge CLK); n++; end
    #1;
    check_all("rst_held.", 4'b0, 4'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    ph[0] = M_IDLE;
    ph[1] = M_IDLE;
  endtask

  initial begin
    int lvl, len;
    ph[0] = M_IDLE; ph[1] = M_IDLE;
    t0[0] = 0; t0[1] = 0; t1[0] = 0; t1[1] = 0;
    #1;
    reset_for(4, 1'b1);
    run(1, 3);

    // short press, then long press with repeats
    run(0, 5);  run(1, 15);
    run(0, 40); run(1, 15);
    // long-press threshold boundary
    run(0, 19); run(1, 15);
    run(0, 20); run(1, 15);
    run(0, 21); run(1, 15);
    // double press, then a gap just long enough to split into two gestures
    run(0, 5);  run(1, 4);  run(0, 30); run(1, 15);
    run(0, 5);  run(1, 10); run(0, 5);  run(1, 15);
    run(0, 5);  run(1, 11); run(0, 5);  run(1, 15);
    // reset mid-hold with the key still down
    run(0, 25); reset_for(3, 1'b0);
    run(0, 25); run(1, 15);
    // reset while a short press is pending in the gap
    run(0, 5);  run(1, 4);  reset_for(2, 1'b1);
    run(1, 15);

    repeat (250) begin
      lvl = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                        : int'($urandom_range(1, 14));
      run(lvl[0], len);
      if ($urandom_range(0, 59) == 0) reset_for(int'($urandom_range(1, 4)), key);
    end
    run(1, 15);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
